router_buffer_ctrl: RTL
=======================

// Module: router_buffer_ctrl
// PURPOSE
//  Sequencer for the three per-output-port DataBuffer instances of the 1x3 router.
//  Accepts words from the input port over a valid/ready handshake and decodes the destination field.
//  Drives the shared buffer data bus and generates ie/oe rising-edge pulses so the word reaches
//  the selected buffer's data_output.
//  Tracks a per-port "word available" flag and never overwrites an unread port.
// PARAMETERS
//  DATA_W    32  width of data word / buffer bus
//  DEST_LSB  0   bit position of 2-bit destination field inside in_data
//  CNT_W     8   width of saturating drop counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous reset, active-high
//  in_data     in   DATA_W  input word; dest = in_data[DEST_LSB+1:DEST_LSB]
//  in_valid    in   1       input word present
//  in_ready    out  1       controller can accept in_data this cycle
//  buf_data    out  DATA_W  shared bus to data_input of all three buffers
//  buf_ie      out  3       per-buffer input enable (one-hot pulse)
//  buf_oe      out  3       per-buffer output enable (one-hot pulse)
//  out_valid   out  3       per-port flag: buffer data_output holds an unread word
//  out_read    in   3       per-port consumer acknowledge; clears out_valid[p]
//  drop_count  out  CNT_W   number of words dropped for dest==3, saturating
// BEHAVIOUR
//  Reset: clk and rst are shared with the buffers; rst is asynchronous; all outputs below are registered or decoded from registers.
//   Reset values: state=IDLE, buf_data=0, buf_ie=0, buf_oe=0, out_valid=0, drop_count=0, in_ready=0 while rst high.
//   rst mid-operation aborts the transfer with no pulse completion; the buffers reset to 0 on the same rst.
//  FSM states: IDLE -> LOAD -> XFER -> IDLE.
//  IDLE:
//   in_ready = 1 when dest==3, or when out_valid[dest]==0 (dest decoded combinationally from in_data).
//   Accept = in_valid & in_ready.
//   dest==3: word is dropped, drop_count+1 (holds at all-ones), FSM stays in IDLE; one word per cycle.
//   dest 0..2: buf_data<=in_data, dest_q<=dest, next state LOAD.
//   in_valid with out_valid[dest]==1: in_ready=0 and the word is held upstream; no head-of-line bypass.
//  LOAD (1 cycle):
//   buf_ie[dest_q]=1, all other ie=0; buf_data stable. The buffer captures on this ie low->high edge.
//   in_ready=0. Next state XFER.
//  XFER (1 cycle):
//   buf_oe[dest_q]=1; the buffer copies input_buffer to output_buffer at the end of the cycle.
//   in_ready=0. out_valid[dest_q]<=1 at the end of XFER. Next state IDLE.
//  Pulse rules:
//   ie and oe are each exactly one cycle high and never high in the same cycle.
//   Minimum one low cycle between consecutive ie pulses to the same port, so every transfer presents a fresh rising edge.
//   buf_data changes only on accept, and is held through LOAD and XFER.
//  Throughput: 3 cycles per routed word (accept, LOAD, XFER); next accept possible in the cycle after XFER.
//   Latency from accept to out_valid=1 is 3 clocks.
//  out_read[p]:
//   Clears out_valid[p] next edge.
//   Ignored when out_valid[p]==0.
//   A read in the same cycle as the XFER set on port p cannot occur, because XFER only targets empty ports.
//   The set is applied regardless, so set wins.
//   A read in the accept-check cycle uses the old flag: the word stalls one cycle, then is accepted.
//  Multiple out_read bits may be high together; each is handled independently.
//  in_ready does not depend on out_read combinationally (no comb path in->out except dest decode).
// TESTING
//  T1 reset: rst high mid-LOAD -> ie/oe/out_valid/drop_count all 0 the same cycle, FSM IDLE after release.
//  T2 route: in_data=32'hA5A5_0001 with valid -> ie[1] high at cycle+1, oe[1] high at cycle+2.
//     Result: buffer1 data_output=A5A5_0001 and out_valid=3'b010 at cycle+3.
//  T3 full port: a second word to port 1 without out_read -> in_ready=0 and buffer1 holds its value.
//     out_read[1] pulse -> word accepted the following cycle and buffer1 updated.
//  T4 drop: 300 back-to-back words with dest=3 -> in_ready stays 1, drop_count saturates at 255, no ie/oe pulses.
//  T5 streaming: words to ports 0,1,2,0 back-to-back.
//     Required: one-hot pulses, 3-cycle spacing, and the last word to port 0 stalls until out_read[0].
//  T6 edge check: two consecutive words to port 2 with out_read between them.
//     Required: ie[2] low for >=1 cycle between pulses, and the second value is captured.

Source files
------------

// File: rtl/router_buffer_ctrl.sv
// Sequencer for the three per-port DataBuffers of a 1x3 router: accepts a word, presents it
// on the shared bus, pulses ie then oe on the selected buffer, and tracks unread words per port.
module router_buffer_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEST_LSB = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] buf_data,
    output logic [2:0]        buf_ie,
    output logic [2:0]        buf_oe,
    output logic [2:0]        out_valid,
    input  logic [2:0]        out_read,
    output logic [CNT_W-1:0]  drop_count
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StXfer
    } state_e;

    state_e     state_q;
    logic [1:0] dest_q;
    logic [1:0] dest;
    logic [2:0] dest_oh;
    logic [3:0] valid_ext;
    logic [2:0] set_mask;
    logic       accept;

    assign dest      = in_data[DEST_LSB +: 2];
    assign dest_oh   = 3'b001 << dest;
    assign valid_ext = {1'b0, out_valid};

    // dest==3 is always ready since dropped words never touch a buffer
    assign in_ready = !rst && (state_q == StIdle) && ((dest == 2'd3) || !valid_ext[dest]);
    assign accept   = in_valid && in_ready;

    assign set_mask = (state_q == StXfer) ? (3'b001 << dest_q) : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            dest_q     <= 2'd0;
            buf_data   <= '0;
            buf_ie     <= 3'b000;
            buf_oe     <= 3'b000;
            out_valid  <= 3'b000;
            drop_count <= '0;
        end else begin
            buf_ie    <= 3'b000;
            buf_oe    <= 3'b000;
            // A set from XFER wins over a concurrent read of the same port
            out_valid <= (out_valid & ~out_read) | set_mask;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (dest == 2'd3) begin
                            if (drop_count != {CNT_W{1'b1}}) begin
                                drop_count <= drop_count + 1'b1;
                            end
                        end else begin
                            buf_data <= in_data;
                            dest_q   <= dest;
                            buf_ie   <= dest_oh;
                            state_q  <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    buf_oe  <= buf_ie;
                    state_q <= StXfer;
                end
                StXfer: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
